// File: rtl/u_rcv16.sv
// -----------------------------------------------------------------------------
// u_rcv16 - UART serial receiver, oversampled at CELL sys_clk cycles per bit.
//
// Recovers frames of one start bit, WORD_LEN data bits (LSB first) and one
// stop bit. The line is synchronised, the start bit is re-checked at
// mid-cell, each data bit is sampled at mid-cell and the stop bit is checked.
//
// Ports:
//   sys_clk     in   system clock, all state on the rising edge
//   sys_rst     in   asynchronous active-high reset
//   uart_recvH  in   serial line, idle high, asynchronous to sys_clk
//   rec_dataH   out  last good byte, right-aligned, upper bits zero
//   rec_readyH  out  one-cycle pulse when rec_dataH takes a good frame
//   frame_errH  out  one-cycle pulse when the stop bit is sampled low
//   rec_busyH   out  high while a frame is in progress
// -----------------------------------------------------------------------------
module u_rcv16 #(
    parameter int WORD_LEN = 8,
    parameter int CELL     = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_recvH,
    output logic [7:0] rec_dataH,
    output logic       rec_readyH,
    output logic       frame_errH,
    output logic       rec_busyH
);

    localparam int CNT_W = $clog2(CELL);
    localparam int SH_ALIGN = 8 - WORD_LEN;
    localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(CELL / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_END   = CNT_W'(CELL - 1);
    localparam logic [3:0]       BITS_LAST = 4'(WORD_LEN - 1);

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } state_t;

    // synchroniser chain; all reset high so reset can never look like a start edge
    logic             sync_a_r;
    logic             line_sync_r;
    logic             line_prev_r;

    state_t           state_r;
    state_t           state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;
    logic [3:0]       bits_r;
    logic [3:0]       bits_nx_s;
    logic [7:0]       sh_r;
    logic [7:0]       sh_nx_s;
    logic [7:0]       data_r;
    logic [7:0]       data_nx_s;
    logic             ready_r;
    logic             ready_nx_s;
    logic             ferr_r;
    logic             ferr_nx_s;
    logic             busy_r;

    // Two-flop synchroniser plus one delay stage for falling-edge detection
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_a_r    <= 1'b1;
            line_sync_r <= 1'b1;
            line_prev_r <= 1'b1;
        end else begin
            sync_a_r    <= uart_recvH;
            line_sync_r <= sync_a_r;
            line_prev_r <= line_sync_r;
        end
    end

    // Next-state and output decode for the frame FSM
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        bits_nx_s  = bits_r;
        sh_nx_s    = sh_r;
        data_nx_s  = data_r;
        ready_nx_s = 1'b0;
        ferr_nx_s  = 1'b0;

        case (state_r)
            R_IDLE: begin
                cnt_nx_s  = '0;
                bits_nx_s = 4'd0;
                // only a fresh 1->0 edge arms; a line stuck low stays idle
                if (line_prev_r && !line_sync_r) begin
                    state_nx_s = R_START;
                end else begin
                    state_nx_s = R_IDLE;
                end
            end

            R_START: begin
                if (cnt_r == CNT_MID) begin
                    cnt_nx_s = '0;
                    if (!line_sync_r) begin
                        state_nx_s = R_DATA;
                    end else begin
                        // start bit vanished before mid-cell: treat as glitch
                        state_nx_s = R_IDLE;
                    end
                end else begin
                    cnt_nx_s = cnt_r + 1'b1;
                end
            end

            R_DATA: begin
                if (cnt_r == CNT_END) begin
                    cnt_nx_s  = '0;
                    sh_nx_s   = {line_sync_r, sh_r[7:1]};
                    bits_nx_s = bits_r + 4'd1;
                    if (bits_r == BITS_LAST) begin
                        state_nx_s = R_STOP;
                    end else begin
                        state_nx_s = R_DATA;
                    end
                end else begin
                    cnt_nx_s = cnt_r + 1'b1;
                end
            end

            R_STOP: begin
                if (cnt_r == CNT_END) begin
                    cnt_nx_s   = '0;
                    bits_nx_s  = 4'd0;
                    state_nx_s = R_IDLE;
                    if (line_sync_r) begin
                        // data entered from the top, so shorter words sit high
                        data_nx_s  = sh_r >> SH_ALIGN;
                        ready_nx_s = 1'b1;
                    end else begin
                        ferr_nx_s = 1'b1;
                    end
                end else begin
                    cnt_nx_s = cnt_r + 1'b1;
                end
            end

            default: begin
                state_nx_s = R_IDLE;
                cnt_nx_s   = '0;
                bits_nx_s  = 4'd0;
            end
        endcase
    end

    // Frame state, counters, shift register and registered outputs
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r <= R_IDLE;
            cnt_r   <= '0;
            bits_r  <= 4'd0;
            sh_r    <= 8'd0;
            data_r  <= 8'd0;
            ready_r <= 1'b0;
            ferr_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            bits_r  <= bits_nx_s;
            sh_r    <= sh_nx_s;
            data_r  <= data_nx_s;
            ready_r <= ready_nx_s;
            ferr_r  <= ferr_nx_s;
            busy_r  <= (state_nx_s != R_IDLE);
        end
    end

    assign rec_dataH  = data_r;
    assign rec_readyH = ready_r;
    assign frame_errH = ferr_r;
    assign rec_busyH  = busy_r;

endmodule
